// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the MIPS-subset datapath: walks FETCH/DECODE/EXEC/MEM/WB and
// drives PC, IR, register-file, ALU and memory strobes so one ALU and one memory serve all phases.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstPC,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             memReady,
    output logic             memReq,
    output logic             memWE,
    output logic             iorD,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             pcSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUCtrl,
    output logic             regDst,
    output logic             memToReg,
    output logic             regWrite,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic       is_rtype, is_lw, is_sw, is_beq, is_addi;
    logic       funct_ok, is_legal;
    logic [3:0] r_alu_ctrl;

    always_comb begin
        is_rtype   = (opcode == OP_RTYPE);
        is_lw      = (opcode == OP_LW);
        is_sw      = (opcode == OP_SW);
        is_beq     = (opcode == OP_BEQ);
        is_addi    = (opcode == OP_ADDI);
        funct_ok   = 1'b1;
        r_alu_ctrl = ALU_ADD;
        case (funct)
            FN_ADD:  r_alu_ctrl = ALU_ADD;
            FN_SUB:  r_alu_ctrl = ALU_SUB;
            FN_AND:  r_alu_ctrl = ALU_AND;
            FN_OR:   r_alu_ctrl = ALU_OR;
            FN_SLT:  r_alu_ctrl = ALU_SLT;
            default: funct_ok   = 1'b0;
        endcase
        is_legal = (is_rtype && funct_ok) || is_lw || is_sw || is_beq || is_addi;
    end

    // Next-state logic; the wait counter only advances while a memory access is outstanding.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        illegal_d  = illegal_q;
        retired_d  = retired_q;
        case (state_q)
            S_FETCH: begin
                if (memReady) begin
                    state_d = S_DECODE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                state_d = is_legal ? S_EXEC : S_ERROR;
            end
            S_EXEC: begin
                if ((is_rtype && funct_ok) || is_addi) begin
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_beq) begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + CNT_W'(1);
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_MEM: begin
                if (memReady) begin
                    if (is_sw) begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + CNT_W'(1);
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end
        if (state_d == S_ERROR) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstPC) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            retired_q  <= retired_d;
        end
    end

    // Strobes follow the registered state; reset masks them so an abandoned instruction writes nothing.
    always_comb begin
        memReq   = 1'b0;
        memWE    = 1'b0;
        iorD     = 1'b0;
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUCtrl  = 4'b0000;
        regDst   = 1'b0;
        memToReg = 1'b0;
        regWrite = 1'b0;
        case (state_q)
            S_FETCH: begin
                memReq = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUCtrl = ALU_ADD;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUCtrl = ALU_ADD;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                if (is_rtype) begin
                    ALUSrcB = 2'b00;
                    ALUCtrl = r_alu_ctrl;
                end else if (is_beq) begin
                    ALUSrcB = 2'b00;
                    ALUCtrl = ALU_SUB;
                    pcWrite = zero;
                    pcSrc   = 1'b1;
                end else begin
                    ALUSrcB = 2'b10;
                    ALUCtrl = ALU_ADD;
                end
            end
            S_MEM: begin
                memReq = 1'b1;
                iorD   = 1'b1;
                memWE  = is_sw;
            end
            S_WB: begin
                regWrite = 1'b1;
                regDst   = is_rtype;
                memToReg = is_lw;
            end
            default: begin
            end
        endcase
        if (rstPC) begin
            memReq   = 1'b0;
            memWE    = 1'b0;
            iorD     = 1'b0;
            irWrite  = 1'b0;
            pcWrite  = 1'b0;
            pcSrc    = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            ALUCtrl  = 4'b0000;
            regDst   = 1'b0;
            memToReg = 1'b0;
            regWrite = 1'b0;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle stimulus and expected strobes are queued per
// instruction, then replayed one cycle at a time and compared against the DUT outputs.
module tb_multicycle_controller;

    localparam int CNT_W = 32;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             rstPC;
    logic [5:0]       opcode, funct;
    logic             zero, memReady;
    logic             memReq, memWE, iorD, irWrite, pcWrite, pcSrc, ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [3:0]       ALUCtrl;
    logic             regDst, memToReg, regWrite, illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstPC(rstPC), .opcode(opcode), .funct(funct), .zero(zero),
        .memReady(memReady), .memReq(memReq), .memWE(memWE), .iorD(iorD),
        .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .regDst(regDst), .memToReg(memToReg),
        .regWrite(regWrite), .state(state), .illegal(illegal), .retired(retired)
    );

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [15:0] vec;
        logic        rdy;
        logic        z;
        logic        rst;
    } cyc_t;

    cyc_t sb[$];

    // Strobe vector: {memReq,memWE,iorD,irWrite,pcWrite,pcSrc,ALUSrcA,ALUSrcB,ALUCtrl,regDst,memToReg,regWrite}
    function automatic logic [15:0] mk(input logic req, we, iord, irw, pcw, pcs, srca,
                                       input logic [1:0] srcb, input logic [3:0] ctrl,
                                       input logic rdst, m2r, rw);
        return {req, we, iord, irw, pcw, pcs, srca, srcb, ctrl, rdst, m2r, rw};
    endfunction

    logic [15:0] V_ZERO, V_FWAIT, V_FDONE, V_DEC, V_EXI, V_WBR, V_WBA, V_WBL;

    function automatic logic [15:0] v_exr(input logic [3:0] c);
        return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, c, 0, 0, 0);
    endfunction
    function automatic logic [15:0] v_beq(input logic z);
        return mk(0, 0, 0, 0, z, 1, 1, 2'b00, 4'b0110, 0, 0, 0);
    endfunction
    function automatic logic [15:0] v_mem(input logic we);
        return mk(1, we, 1, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0);
    endfunction

    task automatic push(input string tag, input logic [2:0] st, input logic [15:0] v,
                        input logic rdy, input logic z = 1'b0, input logic rst = 1'b0);
        cyc_t c;
        c.tag = tag; c.st = st; c.vec = v; c.rdy = rdy; c.z = z; c.rst = rst;
        sb.push_back(c);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run();
        cyc_t c;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            @(negedge clk);
            memReady = c.rdy;
            zero     = c.z;
            rstPC    = c.rst;
            #1;
            chk({c.tag, " state"}, {29'd0, state}, {29'd0, c.st});
            chk({c.tag, " strobes"},
                {16'd0, memReq, memWE, iorD, irWrite, pcWrite, pcSrc, ALUSrcA, ALUSrcB,
                 ALUCtrl, regDst, memToReg, regWrite},
                {16'd0, c.vec});
            $display("[TB] cycle %s state=%0d strobes=%04h", c.tag, state,
                     {memReq, memWE, iorD, irWrite, pcWrite, pcSrc, ALUSrcA, ALUSrcB,
                      ALUCtrl, regDst, memToReg, regWrite});
        end
    endtask

    task automatic after(input string tag, input logic [2:0] st, input logic [31:0] ret,
                         input logic ill);
        @(posedge clk);
        #1;
        chk({tag, " next state"}, {29'd0, state}, {29'd0, st});
        chk({tag, " retired"}, retired, ret);
        chk({tag, " illegal"}, {31'd0, illegal}, {31'd0, ill});
    endtask

    task automatic front(input string tag);
        push({tag, "/fetch"}, 3'd0, V_FDONE, 1'b1);
        push({tag, "/decode"}, 3'd1, V_DEC, 1'b1);
    endtask

    logic [5:0] r_fn[3];
    logic [3:0] r_ctl[3];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        V_ZERO  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0);
        V_FWAIT = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0);
        V_FDONE = mk(1, 0, 0, 1, 1, 0, 0, 2'b01, 4'b0010, 0, 0, 0);
        V_DEC   = mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0010, 0, 0, 0);
        V_EXI   = mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010, 0, 0, 0);
        V_WBR   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 0, 1);
        V_WBA   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 1);
        V_WBL   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 1, 1);
        r_fn[0] = 6'h24; r_ctl[0] = 4'b0000;
        r_fn[1] = 6'h25; r_ctl[1] = 4'b0001;
        r_fn[2] = 6'h2A; r_ctl[2] = 4'b0111;

        rstPC = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; memReady = 1'b1;
        @(negedge clk);
        #1;
        chk("reset strobes", {16'd0, memReq, memWE, iorD, irWrite, pcWrite, pcSrc, ALUSrcA,
                              ALUSrcB, ALUCtrl, regDst, memToReg, regWrite}, 32'd0);
        chk("reset state", {29'd0, state}, 32'd0);
        chk("reset retired", retired, 32'd0);
        chk("reset illegal", {31'd0, illegal}, 32'd0);

        // add, no wait states
        opcode = 6'h00; funct = 6'h20;
        front("add");
        push("add/exec", 3'd2, v_exr(4'b0010), 1'b1);
        push("add/wb", 3'd4, V_WBR, 1'b1);
        run();
        after("add", 3'd0, 32'd1, 1'b0);

        // sub with one fetch wait state
        funct = 6'h22;
        push("sub/fetchwait", 3'd0, V_FWAIT, 1'b0);
        front("sub");
        push("sub/exec", 3'd2, v_exr(4'b0110), 1'b0);
        push("sub/wb", 3'd4, V_WBR, 1'b0);
        run();
        after("sub", 3'd0, 32'd2, 1'b0);

        // lw with memReady delayed three cycles in MEM
        opcode = 6'h23;
        front("lw");
        push("lw/exec", 3'd2, V_EXI, 1'b1);
        for (int i = 0; i < 3; i++) push("lw/memwait", 3'd3, v_mem(1'b0), 1'b0);
        push("lw/memdone", 3'd3, v_mem(1'b0), 1'b1);
        push("lw/wb", 3'd4, V_WBL, 1'b0);
        run();
        after("lw", 3'd0, 32'd3, 1'b0);

        // beq taken then not taken
        opcode = 6'h04;
        front("beq1");
        push("beq1/exec", 3'd2, v_beq(1'b1), 1'b1, 1'b1);
        run();
        after("beq1", 3'd0, 32'd4, 1'b0);
        front("beq0");
        push("beq0/exec", 3'd2, v_beq(1'b0), 1'b1, 1'b0);
        run();
        after("beq0", 3'd0, 32'd5, 1'b0);

        // and / or / slt ALU controls
        opcode = 6'h00;
        for (int k = 0; k < 3; k++) begin
            funct = r_fn[k];
            front("rop");
            push("rop/exec", 3'd2, v_exr(r_ctl[k]), 1'b1);
            push("rop/wb", 3'd4, V_WBR, 1'b1);
            run();
            after("rop", 3'd0, 32'(6 + k), 1'b0);
        end

        // sw completing immediately
        opcode = 6'h2B;
        front("sw");
        push("sw/exec", 3'd2, V_EXI, 1'b0);
        push("sw/mem", 3'd3, v_mem(1'b1), 1'b1);
        run();
        after("sw", 3'd0, 32'd9, 1'b0);

        // sw that never gets memReady: timeout into ERROR
        front("swto");
        push("swto/exec", 3'd2, V_EXI, 1'b0);
        for (int i = 0; i < TMO; i++) push("swto/memwait", 3'd3, v_mem(1'b1), 1'b0);
        push("swto/error", 3'd7, V_ZERO, 1'b1);
        run();
        after("swto", 3'd7, 32'd9, 1'b1);
        push("swto/rst", 3'd7, V_ZERO, 1'b1, 1'b0, 1'b1);
        run();
        after("swto rst", 3'd0, 32'd0, 1'b0);

        // reset asserted during WB of addi
        opcode = 6'h08;
        front("addirst");
        push("addirst/exec", 3'd2, V_EXI, 1'b1);
        push("addirst/wb", 3'd4, V_ZERO, 1'b1, 1'b0, 1'b1);
        run();
        after("addirst", 3'd0, 32'd0, 1'b0);

        // addi completing normally
        front("addi");
        push("addi/exec", 3'd2, V_EXI, 1'b1);
        push("addi/wb", 3'd4, V_WBA, 1'b1);
        run();
        after("addi", 3'd0, 32'd1, 1'b0);

        // illegal opcode, then reset
        opcode = 6'h3F;
        front("op3f");
        push("op3f/error", 3'd7, V_ZERO, 1'b1);
        run();
        after("op3f", 3'd7, 32'd1, 1'b1);
        push("op3f/rst", 3'd7, V_ZERO, 1'b0, 1'b0, 1'b1);
        run();
        after("op3f rst", 3'd0, 32'd0, 1'b0);

        // illegal R-type funct
        opcode = 6'h00; funct = 6'h00;
        front("badfn");
        push("badfn/error", 3'd7, V_ZERO, 1'b1);
        run();
        after("badfn", 3'd7, 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
